// File: rtl/contador_botones.sv
// Up/down event counter fed by conditioned button pulses.
// Wrap flags mark roll-over; activity stretches each accepted event.
module contador_botones #(
  parameter int WIDTH          = 6,
  parameter int STRETCH_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc_pulse,
  input  logic             dec_pulse,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             wrap_up,
  output logic             wrap_down,
  output logic             activity
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [23:0] HOLD_LOAD =
    24'(STRETCH_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  logic [WIDTH-1:0] r_count;
  logic             r_wrap_up;
  logic             r_wrap_down;
  state_t           r_state;
  logic [23:0]      r_hold;

  logic             w_inc;
  logic             w_dec;
  logic             w_evt;
  logic [WIDTH-1:0] w_count_nxt;
  state_t           w_state_nxt;
  logic [23:0]      w_hold_nxt;

  assign w_inc = enable & inc_pulse
               & ~dec_pulse & ~clear;
  assign w_dec = enable & dec_pulse
               & ~inc_pulse & ~clear;
  assign w_evt = w_inc | w_dec;

  always_comb begin
    w_count_nxt = r_count;
    unique case (1'b1)
      clear:   w_count_nxt = '0;
      w_inc:   w_count_nxt = r_count + 1'b1;
      w_dec:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count     <= '0;
      r_wrap_up   <= 1'b0;
      r_wrap_down <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_wrap_up   <= w_inc & (r_count == MAX);
      r_wrap_down <= w_dec & (r_count == '0);
    end
  end

  // Any accepted event (re)loads the stretch timer.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    unique case (r_state)
      IDLE: begin
        if (w_evt) begin
          w_state_nxt = HOLD;
          w_hold_nxt  = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (w_evt) begin
          w_hold_nxt = HOLD_LOAD;
        end else if (r_hold == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_hold_nxt = r_hold - 24'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  assign count     = r_count;
  assign wrap_up   = r_wrap_up;
  assign wrap_down = r_wrap_down;
  assign activity  = (r_state == HOLD);

endmodule

// File: tb/tb_contador_botones.sv
// Directed bench for contador_botones, WIDTH=6, STRETCH_CYCLES=4.
// Vector table plus hand sequences for stretch and async reset.
module tb_contador_botones;

  logic       clk;
  logic       reset_n;
  logic       inc_pulse;
  logic       dec_pulse;
  logic       clear;
  logic       enable;
  logic [5:0] count;
  logic       wrap_up;
  logic       wrap_down;
  logic       activity;

  int n_pass;
  int n_total;

  contador_botones #(
    .WIDTH(6),
    .STRETCH_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse),
    .clear(clear),
    .enable(enable),
    .count(count),
    .wrap_up(wrap_up),
    .wrap_down(wrap_down),
    .activity(activity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       inc;
    logic       dec;
    logic       clr;
    logic       en;
    logic [5:0] cnt;
    logic       wu;
    logic       wd;
    logic       act;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name,
                       input int act,
                       input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
  endtask

  task automatic step(input logic i, input logic d,
                      input logic c, input logic e);
    inc_pulse = i;
    dec_pulse = d;
    clear     = c;
    enable    = e;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 1);
  endtask

  // Count further high cycles of activity, bounded.
  task automatic count_act(inout int n);
    int guard;
    guard = 0;
    while (activity && guard < 20) begin
      step(0, 0, 0, 1);
      if (activity) n++;
      guard++;
    end
    if (guard >= 20) check("act_timeout", guard, 0);
  endtask

  function automatic vec_t mk(
    input logic i, input logic d, input logic c,
    input logic e, input logic [5:0] cn,
    input logic u, input logic w, input logic a);
    vec_t v;
    v.inc = i; v.dec = d; v.clr = c; v.en = e;
    v.cnt = cn; v.wu = u; v.wd = w; v.act = a;
    return v;
  endfunction

  initial begin
    int n;
    n_pass  = 0;
    n_total = 0;

    vecs[0]  = mk(1, 0, 0, 1,  1, 0, 0, 1);
    vecs[1]  = mk(1, 0, 0, 1,  2, 0, 0, 1);
    vecs[2]  = mk(1, 0, 0, 1,  3, 0, 0, 1);
    vecs[3]  = mk(0, 0, 0, 1,  3, 0, 0, 1);
    vecs[4]  = mk(0, 0, 0, 1,  3, 0, 0, 1);
    vecs[5]  = mk(0, 0, 0, 1,  3, 0, 0, 1);
    vecs[6]  = mk(0, 0, 0, 1,  3, 0, 0, 0);
    vecs[7]  = mk(1, 1, 0, 1,  3, 0, 0, 0);
    vecs[8]  = mk(1, 0, 0, 0,  3, 0, 0, 0);
    vecs[9]  = mk(1, 0, 0, 0,  3, 0, 0, 0);
    vecs[10] = mk(0, 1, 0, 0,  3, 0, 0, 0);
    vecs[11] = mk(1, 0, 1, 1,  0, 0, 0, 0);
    vecs[12] = mk(0, 1, 0, 1, 63, 0, 1, 1);
    vecs[13] = mk(0, 0, 0, 1, 63, 0, 0, 1);
    vecs[14] = mk(1, 0, 0, 1,  0, 1, 0, 1);
    vecs[15] = mk(0, 0, 0, 1,  0, 0, 0, 1);
    vecs[16] = mk(1, 0, 0, 1,  1, 0, 0, 1);
    vecs[17] = mk(1, 0, 0, 0,  1, 0, 0, 1);
    vecs[18] = mk(0, 0, 0, 0,  1, 0, 0, 1);
    vecs[19] = mk(0, 0, 0, 0,  1, 0, 0, 1);
    vecs[20] = mk(0, 0, 0, 0,  1, 0, 0, 0);
    vecs[21] = mk(0, 0, 1, 1,  0, 0, 0, 0);

    reset_n   = 1'b0;
    inc_pulse = 1'b0;
    dec_pulse = 1'b0;
    clear     = 1'b0;
    enable    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_wu", wrap_up, 0);
    check("rst_wd", wrap_down, 0);
    check("rst_act", activity, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      step(vecs[i].inc, vecs[i].dec,
           vecs[i].clr, vecs[i].en);
      check($sformatf("v%0d_count", i), count, vecs[i].cnt);
      check($sformatf("v%0d_wu", i), wrap_up, vecs[i].wu);
      check($sformatf("v%0d_wd", i), wrap_down, vecs[i].wd);
      check($sformatf("v%0d_act", i), activity, vecs[i].act);
    end

    // Isolated pulse: four cycles of activity.
    idle_n(5);
    step(1, 0, 0, 1);
    n = activity ? 1 : 0;
    count_act(n);
    check("stretch_single", n, 4);

    // Retrigger two cycles after the first pulse.
    idle_n(5);
    n = 0;
    step(1, 0, 0, 1); if (activity) n++;
    step(0, 0, 0, 1); if (activity) n++;
    step(1, 0, 0, 1); if (activity) n++;
    count_act(n);
    check("stretch_retrig", n, 6);

    // Held pulse counts once per cycle.
    step(0, 0, 1, 1);
    check("held_clr", count, 0);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 1);
    check("held_inc3", count, 3);

    // Count 10, both pulses together.
    step(0, 0, 1, 1);
    for (int k = 0; k < 10; k++) step(1, 0, 0, 1);
    check("ten_count", count, 10);
    idle_n(5);
    check("ten_idle_act", activity, 0);
    step(1, 1, 0, 1);
    check("both_count", count, 10);
    check("both_wu", wrap_up, 0);
    check("both_wd", wrap_down, 0);
    check("both_act", activity, 0);
    step(1, 0, 1, 1);
    check("clr_inc_count", count, 0);
    check("clr_inc_wu", wrap_up, 0);

    // Async reset mid-HOLD at count 20.
    for (int k = 0; k < 20; k++) step(1, 0, 0, 1);
    check("pre_rst_count", count, 20);
    check("pre_rst_act", activity, 1);
    inc_pulse = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_act", activity, 0);
    check("arst_wu", wrap_up, 0);
    @(posedge clk);
    #1;
    check("rst_pulse_count", count, 0);
    check("rst_pulse_act", activity, 0);
    reset_n = 1'b1;
    step(1, 0, 0, 1);
    check("post_rst_count", count, 1);
    check("post_rst_act", activity, 1);
    step(0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/contador_botones.md
CONTADOR_BOTONES -- requirements
Module: contador_botones

Interface
REQ-001 Parameter WIDTH, default 6, SHALL set the counter width in bits; MAX = 2^WIDTH - 1.
REQ-002 Parameter STRETCH_CYCLES, default 4, SHALL set the activity-indicator hold time in clk cycles; valid range is 1 to 2^24 - 1.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  reset; one clock; asynchronous, active-low.
REQ-005 inc_pulse  input  1  single-cycle increment request from a button conditioner; synchronous to clk.
REQ-006 dec_pulse  input  1  single-cycle decrement request from a button conditioner; synchronous to clk.
REQ-007 clear  input  1  synchronous clear of count to 0.
REQ-008 enable  input  1  when low, inc_pulse and dec_pulse SHALL be ignored.
REQ-009 count  output  WIDTH  registered counter value.
REQ-010 wrap_up  output  1  one-cycle flag: an increment took count from MAX to 0.
REQ-011 wrap_down  output  1  one-cycle flag: a decrement took count from 0 to MAX.
REQ-012 activity  output  1  stretched indicator; high while an accepted event is being displayed.

Function
REQ-013 Accepted increment = enable & inc_pulse & ~dec_pulse & ~clear; accepted decrement = enable & dec_pulse & ~inc_pulse & ~clear.
REQ-014 On an accepted increment, count SHALL become (count + 1) mod 2^WIDTH on the next rising edge.
REQ-015 On an accepted decrement, count SHALL become (count - 1) mod 2^WIDTH on the next rising edge.
REQ-016 inc_pulse and dec_pulse both high in the same cycle SHALL leave count unchanged, assert no wrap flag, and not trigger activity.
REQ-017 clear SHALL have priority over every pulse: count becomes 0 on the next edge; wrap flags stay 0; activity is unaffected.
REQ-018 A pulse held high for N cycles SHALL be treated as N accepted events, one per cycle; no internal edge detection.
REQ-019 wrap_up SHALL be registered and high for exactly the cycle in which count shows the post-wrap value 0; otherwise it SHALL be 0.
REQ-020 wrap_down SHALL be registered and high for exactly the cycle in which count shows the post-wrap value MAX; otherwise it SHALL be 0.
REQ-021 Activity FSM states: IDLE (activity = 0) and HOLD (activity = 1), with a down-counter hold_cnt.
REQ-022 IDLE -> HOLD on an accepted increment or decrement; hold_cnt loads STRETCH_CYCLES - 1.
REQ-023 In HOLD, if a new accepted event arrives, the FSM SHALL stay in HOLD and hold_cnt SHALL reload STRETCH_CYCLES - 1 (retrigger).
REQ-024 In HOLD with no event: if hold_cnt = 0, go to IDLE; else decrement hold_cnt.
REQ-025 activity SHALL be a registered output that rises in the same cycle count changes, so a single isolated event gives exactly STRETCH_CYCLES cycles high.
REQ-026 enable deasserted during HOLD SHALL NOT abort the stretch; it only blocks new events.

Reset
REQ-027 reset_n low SHALL immediately, without waiting for clk, force count = 0, wrap_up = 0, wrap_down = 0, activity = 0, FSM = IDLE, hold_cnt = 0.
REQ-028 Reset asserted mid-HOLD or in the same cycle as a pulse SHALL discard the pending event.
REQ-029 The first clk edge after reset_n rises SHALL already accept pulses.

Verification (WIDTH = 6, STRETCH_CYCLES = 4)
REQ-030 Reset, then 3 single-cycle inc_pulse -> count 1, 2, 3 (each one cycle after its pulse); wrap flags stay 0.
REQ-031 count = 63, one inc_pulse -> count = 0 with wrap_up high for 1 cycle; from 0, one dec_pulse -> count = 63 with wrap_down high for 1 cycle.
REQ-032 count = 10, inc_pulse and dec_pulse high together -> count stays 10, no flags, activity stays 0; clear together with inc_pulse -> count = 0.
REQ-033 Isolated inc_pulse -> activity high for exactly 4 cycles; a second pulse 2 cycles after the first -> activity high for 6 consecutive cycles.
REQ-034 enable = 0 with 5 inc_pulse -> count unchanged, activity 0; inc_pulse held high 3 cycles with enable = 1 -> count += 3.
REQ-035 reset_n pulled low between clk edges during HOLD with count = 20 -> count = 0 and activity = 0 immediately, before the next edge.
